// File: rtl/z80_block_xfer_pkg.sv
// Shared types for the Z80 block-transfer sequencer: register selects,
// flag bit positions and the transfer state encoding.
package z80_block_xfer_pkg;

    typedef logic [2:0] reg_select;

    localparam reg_select REG_BC = 3'd0;
    localparam reg_select REG_DE = 3'd1;
    localparam reg_select REG_HL = 3'd2;
    localparam reg_select REG_AF = 3'd3;

    localparam int FLAG_PV_BIT = 2;

    typedef enum logic [2:0] {
        XFER_IDLE,
        XFER_RD,
        XFER_WR,
        XFER_STEP,
        XFER_CHECK,
        XFER_DONE
    } xfer_state_t;

    function automatic logic is_mem_state(input xfer_state_t s);
        return (s == XFER_RD) || (s == XFER_WR);
    endfunction

endpackage

// File: rtl/z80_block_xfer_mem_wait_timer.sv
// Per-request wait counter: flags expiry on the TIMEOUT-th consecutive
// cycle a memory request goes unacknowledged. TIMEOUT = 0 disables it.
module z80_mem_wait_timer #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expired
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            logic [CW-1:0] r_waitCnt;
            logic          w_atLimit;

            assign w_atLimit = (r_waitCnt == CW'(TIMEOUT - 1));
            assign o_expired = i_active && !i_ack && w_atLimit;

            // Restarts on every ack and whenever no request is outstanding.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_waitCnt <= '0;
                end else if (!i_active || i_ack || w_atLimit) begin
                    r_waitCnt <= '0;
                end else begin
                    r_waitCnt <= r_waitCnt + 1'b1;
                end
            end
        end else begin : g_no_timer
            logic w_unused;
            assign w_unused  = ^{clk, reset_n, i_active, i_ack};
            assign o_expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/z80_block_xfer.sv
// Sequencer for LDI/LDD/LDIR/LDDR: copies (HL) to (DE) over a req/ack port,
// steps the register file and repeats while PV reports BC != 0.
module z80_block_xfer
    import z80_block_xfer_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode_dec,
    input  logic             repeat_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt,
    output reg_select        src1,
    output reg_select        src2,
    input  logic [15:0]      rd1,
    input  logic [15:0]      rd2,
    input  logic [7:0]       reg_f,
    output logic             block_inc,
    output logic             block_dec,
    output logic             mem_req,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ack
);

    xfer_state_t      r_state;
    logic             r_modeDec;
    logic             r_repeat;
    logic [7:0]       r_byte;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_blockInc;
    logic             r_blockDec;
    logic             r_memReq;
    logic             r_memWe;
    logic [CNT_W-1:0] r_iterCnt;

    logic             w_expired;
    logic             w_pv;
    logic             w_unusedFlags;

    z80_mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_active  (is_mem_state(r_state)),
        .i_ack     (mem_ack),
        .o_expired (w_expired)
    );

    assign w_pv          = reg_f[FLAG_PV_BIT];
    assign w_unusedFlags = ^(reg_f & ~(8'h01 << FLAG_PV_BIT));

    assign src1      = REG_HL;
    assign src2      = REG_DE;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign iter_cnt  = r_iterCnt;
    assign block_inc = r_blockInc;
    assign block_dec = r_blockDec;
    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    // HL/DE cannot change while a request is open, so the address is stable.
    assign mem_addr  = r_memReq ? (r_memWe ? rd2 : rd1) : 16'h0000;
    assign mem_wdata = (r_memReq && r_memWe) ? r_byte : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= XFER_IDLE;
            r_modeDec  <= 1'b0;
            r_repeat   <= 1'b0;
            r_byte     <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_blockInc <= 1'b0;
            r_blockDec <= 1'b0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_iterCnt  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_blockInc <= 1'b0;
            r_blockDec <= 1'b0;
            case (r_state)
                XFER_IDLE: begin
                    if (start) begin
                        r_modeDec <= mode_dec;
                        r_repeat  <= repeat_en;
                        r_iterCnt <= '0;
                        r_busy    <= 1'b1;
                        r_memReq  <= 1'b1;
                        r_memWe   <= 1'b0;
                        r_state   <= XFER_RD;
                    end
                end
                XFER_RD: begin
                    if (mem_ack) begin
                        r_byte  <= mem_rdata;
                        r_memWe <= 1'b1;
                        r_state <= XFER_WR;
                    end else if (w_expired) begin
                        r_memReq <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= XFER_DONE;
                    end
                end
                XFER_WR: begin
                    if (mem_ack) begin
                        r_memReq   <= 1'b0;
                        r_memWe    <= 1'b0;
                        r_blockInc <= !r_modeDec;
                        r_blockDec <= r_modeDec;
                        r_state    <= XFER_STEP;
                    end else if (w_expired) begin
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= XFER_DONE;
                    end
                end
                XFER_STEP: begin
                    r_iterCnt <= r_iterCnt + 1'b1;
                    r_state   <= XFER_CHECK;
                end
                XFER_CHECK: begin
                    // The register file has already applied the step, so PV is post-decrement.
                    if (r_repeat && w_pv) begin
                        r_memReq <= 1'b1;
                        r_memWe  <= 1'b0;
                        r_state  <= XFER_RD;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= XFER_DONE;
                    end
                end
                XFER_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= XFER_IDLE;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_memReq <= 1'b0;
                    r_memWe  <= 1'b0;
                    r_state  <= XFER_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_block_xfer.sv
// Self-checking bench for z80_block_xfer with a behavioural register file
// and a wait-state memory; table vectors, random transfers, corner sequences.
module tb_z80_block_xfer;
    import z80_block_xfer_pkg::*;

    localparam int TMO    = 8;
    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, mode_dec, repeat_en;
    logic        busy, done, err;
    logic [15:0] iter_cnt;
    reg_select   src1, src2;
    logic [15:0] rd1, rd2;
    logic [7:0]  reg_f;
    logic        block_inc, block_dec;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;

    z80_block_xfer #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode_dec(mode_dec),
        .repeat_en(repeat_en), .busy(busy), .done(done), .err(err),
        .iter_cnt(iter_cnt), .src1(src1), .src2(src2), .rd1(rd1), .rd2(rd2),
        .reg_f(reg_f), .block_inc(block_inc), .block_dec(block_dec),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Commands from the test sequence into the environment models.
    logic        rfLoad = 1'b0;
    logic [15:0] rfLoadHl = '0, rfLoadDe = '0, rfLoadBc = '0;
    logic        memPoke = 1'b0;
    logic [15:0] memPokeAddr = '0;
    logic [7:0]  memPokeData = '0;
    int          ackWait = 0;

    // Environment state, owned by the model block below.
    logic [15:0] regHl = '0, regDe = '0, regBc = '0;
    logic [7:0]  memArr [0:65535];
    logic [15:0] wrLogAddr [0:255];
    logic [7:0]  wrLogData [0:255];
    int wrTotal = 0, incTotal = 0, decTotal = 0, doneTotal = 0;
    int errTotal = 0, doneErrTotal = 0, stabTotal = 0, reqAge = 0;
    logic        prevReq = 1'b0, prevAck = 1'b0, prevWe = 1'b0;
    logic [15:0] prevAddr = '0;
    logic [7:0]  prevData = '0;

    assign rd1       = (src1 == REG_HL) ? regHl : 16'h0000;
    assign rd2       = (src2 == REG_DE) ? regDe : 16'h0000;
    assign reg_f     = {5'b10101, (regBc != 16'h0000), 2'b01};
    assign mem_rdata = memArr[mem_addr];

    always_comb begin
        mem_ack = mem_req && (ackWait >= 0) && (reqAge >= ackWait);
    end

    // Register file, memory and event counters as seen from outside the DUT.
    always @(posedge clk) begin
        if (rfLoad) begin
            regHl <= rfLoadHl; regDe <= rfLoadDe; regBc <= rfLoadBc;
        end else if (block_inc) begin
            regHl <= regHl + 16'd1; regDe <= regDe + 16'd1; regBc <= regBc - 16'd1;
        end else if (block_dec) begin
            regHl <= regHl - 16'd1; regDe <= regDe - 16'd1; regBc <= regBc - 16'd1;
        end
        if (memPoke) begin
            memArr[memPokeAddr] <= memPokeData;
        end else if (mem_req && mem_ack && mem_we) begin
            memArr[mem_addr]         <= mem_wdata;
            wrLogAddr[wrTotal & 255] <= mem_addr;
            wrLogData[wrTotal & 255] <= mem_wdata;
            wrTotal                  <= wrTotal + 1;
        end
        if (block_inc) incTotal <= incTotal + 1;
        if (block_dec) decTotal <= decTotal + 1;
        if (done) doneTotal <= doneTotal + 1;
        if (err) errTotal <= errTotal + 1;
        if (done && err) doneErrTotal <= doneErrTotal + 1;
        if (mem_req && prevReq && !prevAck &&
            (mem_addr != prevAddr || mem_wdata != prevData || mem_we != prevWe))
            stabTotal <= stabTotal + 1;
        reqAge   <= (mem_req && !mem_ack) ? reqAge + 1 : 0;
        prevReq  <= mem_req;
        prevAck  <= mem_ack;
        prevWe   <= mem_we;
        prevAddr <= mem_addr;
        prevData <= mem_wdata;
    end

    typedef struct {
        logic [15:0] hl, de, bc;
        bit          dec, rep;
        int          waitC, restartAt, nBytes;
        logic [63:0] srcBytes;
        logic [15:0] expHl, expDe, expBc, expIter;
        int          expCycles, expInc, expDec;
    } vec_t;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pokeMem(input logic [15:0] a, input logic [7:0] d);
        memPokeAddr = a;
        memPokeData = d;
        memPoke     = 1'b1;
        @(negedge clk);
        memPoke = 1'b0;
    endtask

    task automatic loadRegs(input logic [15:0] hl, input logic [15:0] de, input logic [15:0] bc);
        rfLoadHl = hl; rfLoadDe = de; rfLoadBc = bc;
        rfLoad   = 1'b1;
        @(negedge clk);
        rfLoad = 1'b0;
    endtask

    // Runs one transfer from a vector and checks every observable result.
    task automatic applyStimulus(input vec_t v, input string tag);
        int busyCycles, srcBad, inc0, dec0, done0, err0, wr0, stab0, nWr;
        logic [15:0] a;
        for (int i = 0; i < v.nBytes; i++) begin
            a = v.dec ? v.hl - 16'(i) : v.hl + 16'(i);
            pokeMem(a, v.srcBytes[8*i +: 8]);
        end
        loadRegs(v.hl, v.de, v.bc);
        ackWait = v.waitC;
        inc0 = incTotal; dec0 = decTotal; done0 = doneTotal; err0 = errTotal;
        wr0 = wrTotal; stab0 = stabTotal;
        start = 1'b1; mode_dec = v.dec; repeat_en = v.rep;
        @(negedge clk);
        start = 1'b0;
        busyCycles = 0;
        srcBad = 0;
        while (busy && busyCycles < BUDGET) begin
            busyCycles++;
            if (src1 != REG_HL || src2 != REG_DE) srcBad++;
            if (busyCycles == v.restartAt) begin
                start = 1'b1; mode_dec = ~v.dec; repeat_en = ~v.rep;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (busyCycles >= BUDGET) $display("[TB] FAIL %s_hang: busy still high after %0d cycles, required low", tag, busyCycles);
        if (busyCycles >= BUDGET) nFails++;
        checkOutput({tag, "_cycles"}, busyCycles, v.expCycles);
        checkOutput({tag, "_iter"}, {16'h0, iter_cnt}, {16'h0, v.expIter});
        checkOutput({tag, "_hl"}, {16'h0, regHl}, {16'h0, v.expHl});
        checkOutput({tag, "_de"}, {16'h0, regDe}, {16'h0, v.expDe});
        checkOutput({tag, "_bc"}, {16'h0, regBc}, {16'h0, v.expBc});
        checkOutput({tag, "_pv"}, {31'h0, reg_f[FLAG_PV_BIT]}, {31'h0, (v.expBc != 16'h0)});
        checkOutput({tag, "_inc"}, incTotal - inc0, v.expInc);
        checkOutput({tag, "_dec"}, decTotal - dec0, v.expDec);
        checkOutput({tag, "_done"}, doneTotal - done0, 1);
        checkOutput({tag, "_err"}, errTotal - err0, 0);
        checkOutput({tag, "_stable"}, stabTotal - stab0, 0);
        checkOutput({tag, "_src"}, srcBad, 0);
        nWr = wrTotal - wr0;
        checkOutput({tag, "_nwr"}, nWr, v.nBytes);
        for (int i = 0; i < v.nBytes && i < nWr; i++) begin
            a = v.dec ? v.de - 16'(i) : v.de + 16'(i);
            checkOutput($sformatf("%s_wa%0d", tag, i), {16'h0, wrLogAddr[(wr0 + i) & 255]}, {16'h0, a});
            checkOutput($sformatf("%s_wd%0d", tag, i), {24'h0, wrLogData[(wr0 + i) & 255]}, {24'h0, v.srcBytes[8*i +: 8]});
        end
    endtask

    vec_t vecs [7];

    initial begin
        vec_t rv;
        int   n, guard, busyCycles, reqCycles, done0, err0, de0, inc0;

        reset_n = 1'b0; start = 1'b0; mode_dec = 1'b0; repeat_en = 1'b0;

        // hl, de, bc, dec, rep, wait, restartAt, nBytes, src, expHl, expDe, expBc, expIter, expCycles, expInc, expDec
        vecs[0] = '{16'h1000, 16'h2000, 16'h0003, 1'b0, 1'b0, 0, 0, 1, 64'h5A,
                    16'h1001, 16'h2001, 16'h0002, 16'd1, 5, 1, 0};
        vecs[1] = '{16'h1000, 16'h2000, 16'h0003, 1'b0, 1'b1, 0, 0, 3, 64'h33_22_11,
                    16'h1003, 16'h2003, 16'h0000, 16'd3, 13, 3, 0};
        vecs[2] = '{16'h10FF, 16'h20FF, 16'h0002, 1'b1, 1'b1, 0, 0, 2, 64'hBB_AA,
                    16'h10FD, 16'h20FD, 16'h0000, 16'd2, 9, 0, 2};
        vecs[3] = '{16'h3000, 16'h4000, 16'h0002, 1'b0, 1'b1, 3, 0, 2, 64'h3C_C3,
                    16'h3002, 16'h4002, 16'h0000, 16'd2, 21, 2, 0};
        vecs[4] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 0, 0, 1, 64'h77,
                    16'hFFFF, 16'hFFFE, 16'h0000, 16'd1, 5, 0, 1};
        vecs[5] = '{16'h5000, 16'h6000, 16'h0010, 1'b0, 1'b0, 1, 0, 1, 64'hE1,
                    16'h5001, 16'h6001, 16'h000F, 16'd1, 7, 1, 0};
        vecs[6] = '{16'h8000, 16'h9000, 16'h0003, 1'b0, 1'b1, 0, 2, 3, 64'h66_55_44,
                    16'h8003, 16'h9003, 16'h0000, 16'd3, 13, 3, 0};

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'h0, busy}, 0);
        checkOutput("rst_done", {31'h0, done}, 0);
        checkOutput("rst_err", {31'h0, err}, 0);
        checkOutput("rst_iter", {16'h0, iter_cnt}, 0);
        checkOutput("rst_req", {31'h0, mem_req}, 0);
        checkOutput("rst_we", {31'h0, mem_we}, 0);
        checkOutput("rst_addr", {16'h0, mem_addr}, 0);
        checkOutput("rst_wdata", {24'h0, mem_wdata}, 0);
        checkOutput("rst_inc", {31'h0, block_inc}, 0);
        checkOutput("rst_dec", {31'h0, block_dec}, 0);
        checkOutput("rst_src1", {29'h0, src1}, {29'h0, REG_HL});
        checkOutput("rst_src2", {29'h0, src2}, {29'h0, REG_DE});
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) applyStimulus(vecs[k], $sformatf("vec%0d", k));

        // Random transfers against a closed-form model of the instruction.
        for (int k = 0; k < 20; k++) begin
            rv.hl        = 16'($urandom);
            rv.de        = rv.hl ^ 16'h8000;
            rv.bc        = 16'($urandom_range(1, 5));
            rv.dec       = 1'($urandom);
            rv.rep       = 1'($urandom);
            rv.waitC     = $urandom_range(0, 4);
            rv.restartAt = 0;
            rv.srcBytes  = {$urandom, $urandom};
            n            = rv.rep ? int'(rv.bc) : 1;
            rv.nBytes    = n;
            rv.expHl     = rv.dec ? rv.hl - 16'(n) : rv.hl + 16'(n);
            rv.expDe     = rv.dec ? rv.de - 16'(n) : rv.de + 16'(n);
            rv.expBc     = rv.bc - 16'(n);
            rv.expIter   = 16'(n);
            rv.expCycles = n * (2 * rv.waitC + 4) + 1;
            rv.expInc    = rv.dec ? 0 : n;
            rv.expDec    = rv.dec ? n : 0;
            applyStimulus(rv, $sformatf("rnd%0d", k));
        end

        // Timeout: memory never acknowledges the read.
        loadRegs(16'h7000, 16'h7100, 16'h0005);
        ackWait = -1;
        done0 = doneTotal; err0 = errTotal; de0 = doneErrTotal; inc0 = incTotal;
        start = 1'b1; mode_dec = 1'b0; repeat_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busyCycles = 0;
        reqCycles = 0;
        while (busy && busyCycles < BUDGET) begin
            busyCycles++;
            if (mem_req) reqCycles++;
            @(negedge clk);
        end
        ackWait = 0;
        checkOutput("tmo_req_cycles", reqCycles, TMO);
        checkOutput("tmo_busy_cycles", busyCycles, TMO + 1);
        checkOutput("tmo_done", doneTotal - done0, 1);
        checkOutput("tmo_err", errTotal - err0, 1);
        checkOutput("tmo_together", doneErrTotal - de0, 1);
        checkOutput("tmo_inc", incTotal - inc0, 0);
        checkOutput("tmo_bc", {16'h0, regBc}, 32'h0005);
        checkOutput("tmo_iter", {16'h0, iter_cnt}, 0);

        // Reset while a write is waiting for its ack.
        loadRegs(16'h1000, 16'h2000, 16'h0003);
        ackWait = 5;
        done0 = doneTotal;
        start = 1'b1; mode_dec = 1'b0; repeat_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(mem_req && mem_we) && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        checkOutput("rstwr_reached_wr", {31'h0, mem_req && mem_we}, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("rstwr_req", {31'h0, mem_req}, 0);
        checkOutput("rstwr_busy", {31'h0, busy}, 0);
        checkOutput("rstwr_inc", {31'h0, block_inc}, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstwr_no_done", doneTotal - done0, 0);
        reset_n = 1'b1;
        ackWait = 0;
        @(negedge clk);
        applyStimulus(vecs[0], "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
